// File: rtl/mem_stage_sram.sv
// Pipeline memory stage: 32-bit loads/stores over a 16-bit SRAM as two
// half-word accesses, each held for WAIT_CYCLES clocks, stalling upstream.
module mem_stage_sram #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_en_in,
  input  logic               mem_r_en_in,
  input  logic               mem_w_en_in,
  input  logic [WORD_W-1:0]  alu_res_in,
  input  logic [WORD_W-1:0]  val_r_m_in,
  input  logic [3:0]         dest_in,
  output logic               wb_en_out,
  output logic               mem_r_en_out,
  output logic [WORD_W-1:0]  alu_res_out,
  output logic [WORD_W-1:0]  mem_data_out,
  output logic [3:0]         dest_out,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  input  logic [15:0]        sram_rdata,
  output logic               sram_we_n
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  logic [1:0]         state, state_next;
  logic [3:0]         count, count_next;
  logic               req;
  logic               last;
  logic               store_req;
  logic [SRAM_AW-2:0] off_in;
  logic               is_write;
  logic [SRAM_AW-2:0] addr_off;
  logic [WORD_W-1:0]  data;
  logic [15:0]        data_lo;

  assign req       = mem_r_en_in | mem_w_en_in;
  assign store_req = mem_w_en_in & ~mem_r_en_in;
  assign last      = (count == WAIT_LAST);
  // Word offset from the SRAM base; below-base addresses wrap, byte bits dropped.
  assign off_in    = (SRAM_AW-1)'((alu_res_in - WORD_W'(ADDR_BASE)) >> 2);

  // Next-state and wait counter.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_next = S_LO;
          count_next = 4'd0;
        end
      end
      S_LO: begin
        if (last) begin
          state_next = S_HI;
          count_next = 4'd0;
        end else begin
          count_next = count + 4'd1;
        end
      end
      S_HI: begin
        if (last) begin
          state_next = S_DONE;
          count_next = 4'd0;
        end else begin
          count_next = count + 4'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        count_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // SRAM bus is registered on the edge entering each phase so it is stable
  // for every cycle of that phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_we_n    <= 1'b1;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      mem_data_out <= '0;
      is_write     <= 1'b0;
      addr_off     <= '0;
      data         <= '0;
      data_lo      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            is_write   <= store_req;
            addr_off   <= off_in;
            data       <= val_r_m_in;
            sram_addr  <= {off_in, 1'b0};
            sram_wdata <= val_r_m_in[15:0];
            sram_we_n  <= ~store_req;
          end
        end
        S_LO: begin
          if (last) begin
            if (!is_write) data_lo <= sram_rdata;
            sram_addr  <= {addr_off, 1'b1};
            sram_wdata <= data[31:16];
          end
        end
        S_HI: begin
          if (last) begin
            sram_we_n <= 1'b1;
            if (!is_write) mem_data_out <= WORD_W'({sram_rdata, data_lo});
          end
        end
        default: begin
          sram_we_n <= 1'b1;
        end
      endcase
    end
  end

  assign freeze       = ~rst & (((state == S_IDLE) & req) | (state == S_LO) | (state == S_HI));
  assign wb_en_out    = wb_en_in & ~freeze;
  assign mem_r_en_out = mem_r_en_in;
  assign alu_res_out  = alu_res_in;
  assign dest_out     = dest_in;

endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram: vector table, hand-written corner sequences and
// random traffic checked against a word-level memory model.
module tb_mem_stage_sram;

  localparam int unsigned WAIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_res_in, val_r_m_in;
  logic [3:0]  dest_in;
  logic        wb_en_out, mem_r_en_out, freeze, sram_we_n;
  logic [31:0] alu_res_out, mem_data_out;
  logic [3:0]  dest_out;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;

  int total = 0;
  int passed = 0;
  logic [31:0] last_load = 32'h0;
  logic [31:0] ref_mem [int unsigned];

  logic [15:0] sram_mem [0:4095] = '{default: 16'h0};

  mem_stage_sram #(.WORD_W(32), .SRAM_AW(18), .ADDR_BASE(1024), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in), .val_r_m_in(val_r_m_in),
    .dest_in(dest_in), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_res_out(alu_res_out), .mem_data_out(mem_data_out), .dest_out(dest_out),
    .freeze(freeze), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM device model: asynchronous read, write on the clock while strobed.
  assign sram_rdata = sram_mem[sram_addr[11:0]];
  always @(posedge clk) if (sram_we_n === 1'b0) sram_mem[sram_addr[11:0]] <= sram_wdata;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int unsigned word_off(input logic [31:0] addr);
    logic [31:0] d;
    d = addr - 32'd1024;
    return (d >> 2) & 32'h1FFFF;
  endfunction

  function automatic logic [31:0] ref_load(input int unsigned off);
    if (ref_mem.exists(off)) return ref_mem[off];
    return 32'h0;
  endfunction

  // One memory access from its first (request) cycle through DONE.
  task automatic run_op(input logic r, input logic w, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_data,
                        input logic [17:0] exp_hw);
    int  frz = 0, wecnt = 0, badwe = 0, wbbad = 0;
    bit  done = 0;
    bit  store;
    store = w && !r;
    @(posedge clk); #1;
    mem_r_en_in = r; mem_w_en_in = w; alu_res_in = addr; val_r_m_in = wd;
    wb_en_in = r; dest_in = 4'd7;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 0) check("freeze_start", 64'(freeze), 64'd1);
      if (freeze === 1'b1) begin
        frz++;
        if (wb_en_out !== 1'b0) wbbad++;
        if (sram_we_n === 1'b0) begin
          if (wecnt < int'(WAIT)) begin
            if (sram_addr !== exp_hw || sram_wdata !== wd[15:0]) badwe++;
          end else begin
            if (sram_addr !== exp_hw + 18'd1 || sram_wdata !== wd[31:16]) badwe++;
          end
          wecnt++;
        end
      end else begin
        done = 1;
        check("freeze_cycles", 64'(frz), 64'(2 * WAIT + 1));
        check("we_cycles", 64'(wecnt), store ? 64'(2 * WAIT) : 64'd0);
        check("we_bus", 64'(badwe), 64'd0);
        check("wb_frozen", 64'(wbbad), 64'd0);
        check("we_done", 64'(sram_we_n), 64'd1);
        check("wb_done", 64'(wb_en_out), 64'(r));
        if (store) check("data_hold", 64'(mem_data_out), 64'(last_load));
        else begin
          check("load_data", 64'(mem_data_out), 64'(exp_data));
          last_load = exp_data;
        end
      end
    end
    if (!done) check("timeout", 64'd0, 64'd1);
    if (store) ref_mem[word_off(addr)] = wd;
  endtask

  task automatic run_nonmem(input logic [31:0] res, input logic [3:0] d, input logic wb);
    @(posedge clk); #1;
    mem_r_en_in = 0; mem_w_en_in = 0; alu_res_in = res; dest_in = d; wb_en_in = wb;
    @(negedge clk);
    check("nm_freeze", 64'(freeze), 64'd0);
    check("nm_wb", 64'(wb_en_out), 64'(wb));
    check("nm_alu", 64'(alu_res_out), 64'(res));
    check("nm_dest", 64'(dest_out), 64'(d));
    check("nm_mre", 64'(mem_r_en_out), 64'd0);
  endtask

  typedef struct {
    logic        r, w;
    logic [31:0] addr, wd, exp_data;
    logic [17:0] exp_hw;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{r:0, w:1, addr:32'd1028, wd:32'hDEADBEEF, exp_data:32'h0,        exp_hw:18'd2};
    tbl[1] = '{r:1, w:0, addr:32'd1028, wd:32'h0,        exp_data:32'hDEADBEEF, exp_hw:18'd2};
    tbl[2] = '{r:0, w:1, addr:32'd1030, wd:32'hCAFEF00D, exp_data:32'h0,        exp_hw:18'd2};
    tbl[3] = '{r:1, w:0, addr:32'd1031, wd:32'h0,        exp_data:32'hCAFEF00D, exp_hw:18'd2};
    tbl[4] = '{r:1, w:1, addr:32'd1024, wd:32'h11111111, exp_data:32'h0,        exp_hw:18'd0};
    tbl[5] = '{r:1, w:0, addr:32'd1024, wd:32'h0,        exp_data:32'h0,        exp_hw:18'd0};
    tbl[6] = '{r:0, w:1, addr:32'd1020, wd:32'hA5A55A5A, exp_data:32'h0,        exp_hw:18'h3FFFE};
    tbl[7] = '{r:1, w:0, addr:32'd1020, wd:32'h0,        exp_data:32'hA5A55A5A, exp_hw:18'h3FFFE};

    rst = 1; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    alu_res_in = 0; val_r_m_in = 0; dest_in = 0;
    repeat (2) begin
      @(negedge clk);
      check("rst_freeze", 64'(freeze), 64'd0);
    end
    check("rst_we", 64'(sram_we_n), 64'd1);
    check("rst_addr", 64'(sram_addr), 64'd0);
    check("rst_data", 64'(mem_data_out), 64'd0);
    @(posedge clk); #1; rst = 0;
    run_nonmem(32'h55, 4'd3, 1'b1);

    // Vector table; consecutive entries also exercise back-to-back accesses.
    for (int i = 0; i < 8; i++)
      run_op(tbl[i].r, tbl[i].w, tbl[i].addr, tbl[i].wd, tbl[i].exp_data, tbl[i].exp_hw);

    // Random traffic against the word-level model.
    for (int i = 0; i < 40; i++) begin
      int unsigned kind, off;
      logic [31:0] addr, wd;
      kind = $urandom_range(3);
      off  = $urandom_range(63);
      addr = 32'd1024 + 32'(off * 4) + 32'($urandom_range(3));
      wd   = $urandom;
      if (kind == 3) run_nonmem($urandom, 4'($urandom_range(15)), 1'($urandom_range(1)));
      else run_op(kind != 1, kind != 0, addr, wd, ref_load(off), 18'(off * 2));
    end

    // Reset during the high half of a store.
    @(posedge clk); #1;
    mem_r_en_in = 0; mem_w_en_in = 1; alu_res_in = 32'd3024; val_r_m_in = 32'h12345678;
    wb_en_in = 0;
    repeat (4) @(negedge clk);
    check("abort_hi_addr", 64'(sram_addr), 64'd1001);
    check("abort_hi_we", 64'(sram_we_n), 64'd0);
    #1 rst = 1;
    #1 check("abort_rst_freeze", 64'(freeze), 64'd0);
    @(posedge clk); #1;
    rst = 0; mem_w_en_in = 0;
    last_load = 32'h0;
    @(negedge clk);
    check("abort_we", 64'(sram_we_n), 64'd1);
    check("abort_data", 64'(mem_data_out), 64'd0);
    check("abort_freeze", 64'(freeze), 64'd0);
    run_op(1'b1, 1'b0, 32'd1028, 32'h0, ref_load(1), 18'd2);
    run_nonmem(32'hA0A0, 4'd9, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
